// File: rtl/dmem_write_buffer.sv
// Line-granular write buffer between the D-cache memory-side port and slow data memory.
// Absorbs cache write-backs, drains them in FIFO order and serves reads that hit buffered lines.
module dmem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 28,
    parameter int DW    = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   c_read,
    input  logic                   c_write,
    input  logic [AW-1:0]          c_addr,
    input  logic [DW-1:0]          c_wdata,
    output logic [DW-1:0]          c_rdata,
    output logic                   c_ready,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    input  logic [DW-1:0]          mem_rdata,
    input  logic                   mem_ready,
    output logic                   wb_empty,
    output logic [$clog2(DEPTH):0] wb_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ} mstate_t;

    mstate_t          state_reg, state_next;
    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [PW-1:0]    head_reg, head_next;
    logic [PW-1:0]    tail_reg, tail_next;
    logic [PW:0]      count_reg, count_next;
    logic             rd_pending_reg, rd_pending_next;
    logic [AW-1:0]    rd_addr_reg, rd_addr_next;
    logic [DW-1:0]    c_rdata_reg, c_rdata_next;
    logic             c_ready_reg, c_ready_next;
    logic             mem_read_reg, mem_read_next;
    logic             mem_write_reg, mem_write_next;
    logic [AW-1:0]    mem_addr_reg, mem_addr_next;
    logic [DW-1:0]    mem_wdata_reg, mem_wdata_next;
    logic             wb_empty_reg, wb_empty_next;

    logic             wr_en;
    logic [PW-1:0]    wr_idx;
    logic             push, pop, accept;
    logic             wr_hit, rd_hit;
    logic [PW-1:0]    wr_hit_idx, rd_hit_idx;
    logic [DEPTH-1:0] wr_match;
    logic [DEPTH-1:0] rd_match;
    logic [PW-1:0]    rd_idx [DEPTH];
    logic             head_busy;

    // The head is off-limits for coalescing once its drain has been (or is being) launched,
    // otherwise the new data would be popped without ever reaching memory.
    assign head_busy = (state_reg == M_WRITE) ||
                       (state_reg == M_IDLE && !rd_pending_reg && count_reg != '0);

    // rd_match is ordered oldest-to-youngest so the last hit is the youngest copy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign wr_match[gi] = valid_reg[gi] && (addr_mem[gi] == c_addr) &&
                                  !(head_busy && head_reg == PW'(gi));
            assign rd_idx[gi]   = head_reg + PW'(gi);
            assign rd_match[gi] = valid_reg[rd_idx[gi]] && (addr_mem[rd_idx[gi]] == c_addr);
        end
    endgenerate

    always_comb begin
        wr_hit     = 1'b0;
        wr_hit_idx = '0;
        rd_hit     = 1'b0;
        rd_hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_match[i]) begin
                wr_hit     = 1'b1;
                wr_hit_idx = PW'(i);
            end
            if (rd_match[i]) begin
                rd_hit     = 1'b1;
                rd_hit_idx = rd_idx[i];
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        valid_next      = valid_reg;
        head_next       = head_reg;
        tail_next       = tail_reg;
        rd_pending_next = rd_pending_reg;
        rd_addr_next    = rd_addr_reg;
        c_rdata_next    = c_rdata_reg;
        c_ready_next    = 1'b0;
        mem_read_next   = mem_read_reg;
        mem_write_next  = mem_write_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        wr_en           = 1'b0;
        wr_idx          = tail_reg;
        push            = 1'b0;
        pop             = 1'b0;
        accept          = !c_ready_reg && !rd_pending_reg;

        if (accept && c_write) begin
            if (wr_hit) begin
                wr_en        = 1'b1;
                wr_idx       = wr_hit_idx;
                c_ready_next = 1'b1;
            end else if (count_reg != FULL) begin
                wr_en        = 1'b1;
                push         = 1'b1;
                c_ready_next = 1'b1;
            end
        end else if (accept && c_read) begin
            if (rd_hit) begin
                c_rdata_next = data_mem[rd_hit_idx];
                c_ready_next = 1'b1;
            end else begin
                rd_pending_next = 1'b1;
                rd_addr_next    = c_addr;
            end
        end

        case (state_reg)
            M_IDLE: begin
                if (rd_pending_reg) begin
                    state_next    = M_READ;
                    mem_read_next = 1'b1;
                    mem_addr_next = rd_addr_reg;
                end else if (count_reg != '0) begin
                    state_next     = M_WRITE;
                    mem_write_next = 1'b1;
                    mem_addr_next  = addr_mem[head_reg];
                    mem_wdata_next = data_mem[head_reg];
                end
            end
            M_WRITE: begin
                if (mem_ready) begin
                    pop            = 1'b1;
                    mem_write_next = 1'b0;
                    state_next     = M_IDLE;
                end
            end
            M_READ: begin
                if (mem_ready) begin
                    mem_read_next   = 1'b0;
                    rd_pending_next = 1'b0;
                    c_rdata_next    = mem_rdata;
                    c_ready_next    = 1'b1;
                    state_next      = M_IDLE;
                end
            end
            default: state_next = M_IDLE;
        endcase

        if (pop) begin
            valid_next[head_reg] = 1'b0;
            head_next            = head_reg + PW'(1);
        end
        if (push) begin
            valid_next[tail_reg] = 1'b1;
            tail_next            = tail_reg + PW'(1);
        end
        count_next    = count_reg + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        wb_empty_next = (count_next == '0);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            addr_mem[wr_idx] <= c_addr;
            data_mem[wr_idx] <= c_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= M_IDLE;
            valid_reg      <= '0;
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            rd_pending_reg <= 1'b0;
            rd_addr_reg    <= '0;
            c_rdata_reg    <= '0;
            c_ready_reg    <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            wb_empty_reg   <= 1'b1;
        end else begin
            state_reg      <= state_next;
            valid_reg      <= valid_next;
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            count_reg      <= count_next;
            rd_pending_reg <= rd_pending_next;
            rd_addr_reg    <= rd_addr_next;
            c_rdata_reg    <= c_rdata_next;
            c_ready_reg    <= c_ready_next;
            mem_read_reg   <= mem_read_next;
            mem_write_reg  <= mem_write_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            wb_empty_reg   <= wb_empty_next;
        end
    end

    assign c_rdata   = c_rdata_reg;
    assign c_ready   = c_ready_reg;
    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign wb_empty  = wb_empty_reg;
    assign wb_count  = count_reg;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Bench for dmem_write_buffer: directed scenarios plus random traffic checked against a
// coherent-memory model (a read must return the latest line the cache wrote to that address).
module tb_dmem_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 28;
    localparam int DW    = 128;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_read = 1'b0, c_write = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic [DW-1:0] c_rdata;
    logic          c_ready;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          wb_empty;
    logic [CW-1:0] wb_count;

    always #5 clk = ~clk;

    dmem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ready(c_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .wb_empty(wb_empty), .wb_count(wb_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] phys    [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [AW:0]   tx_log [$];
    int  lat_min = 1, lat_max = 1;
    bit  spurious_en = 1'b0;
    int  wr_ready_edge = 0, rd_start_cyc = 0, tx_starts = 0;
    bit  busy = 1'b0, gap_pending = 1'b0;
    int  cnt = 0, cur_lat = 1;
    logic [AW-1:0] start_addr = '0;

    function automatic logic [DW-1:0] init_line(input logic [AW-1:0] a);
        return {4{4'hC, a}};
    endfunction

    function automatic logic [DW-1:0] phys_rd(input logic [AW-1:0] a);
        return phys.exists(a) ? phys[a] : init_line(a);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Slow-memory model: responds after cur_lat cycles, checks the idle gap and address stability.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
                gap_pending = 1'b0;
                continue;
            end
            if (gap_pending) begin
                chk("idle_gap", DW'(mem_read || mem_write), DW'(0));
                gap_pending = 1'b0;
            end
            if ((mem_read || mem_write) && !busy) begin
                busy = 1'b1;
                cnt = 0;
                cur_lat = int'($urandom_range(lat_max, lat_min));
                start_addr = mem_addr;
                tx_starts++;
                tx_log.push_back({mem_read, mem_addr});
                if (mem_read) rd_start_cyc = cyc;
            end
            if (busy) begin
                cnt++;
                if (cnt >= cur_lat) begin
                    chk("mem_addr_stable", DW'(mem_addr), DW'(start_addr));
                    mem_ready = 1'b1;
                    busy = 1'b0;
                    gap_pending = 1'b1;
                    if (mem_write) begin
                        phys[mem_addr] = mem_wdata;
                        wr_ready_edge = cyc + 1;
                    end else begin
                        mem_rdata = phys_rd(mem_addr);
                    end
                end
            end else if (spurious_en && $urandom_range(7, 0) == 0) begin
                mem_ready = 1'b1;
            end
        end
    end

    // All cache tasks start and end #1 after a rising edge.
    task automatic cache_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               output int lat, output int rcyc);
        c_write = 1'b1; c_addr = a; c_wdata = d; lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!c_ready && lat < 300);
        if (!c_ready) chk("write_timeout", DW'(0), DW'(1));
        rcyc = cyc;
        c_write = 1'b0;
        ref_mem[a] = d;
        $display("wr   addr=%h lat=%0d count=%0d", a, lat, wb_count);
        @(posedge clk); #1;
    endtask

    task automatic cache_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        c_read = 1'b1; c_addr = a; lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!c_ready && lat < 300);
        if (!c_ready) chk("read_timeout", DW'(0), DW'(1));
        d = c_rdata;
        c_read = 1'b0;
        $display("rd   addr=%h lat=%0d data=%h", a, lat, d);
        @(posedge clk); #1;
    endtask

    task automatic cache_both(input logic [AW-1:0] a, input logic [DW-1:0] wd, output logic [DW-1:0] d);
        int lat;
        c_write = 1'b1; c_read = 1'b1; c_addr = a; c_wdata = wd; lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!c_ready && lat < 300);
        if (!c_ready) chk("both_wr_timeout", DW'(0), DW'(1));
        c_write = 1'b0;
        ref_mem[a] = wd;
        @(posedge clk); #1;
        lat = 0;
        while (!c_ready && lat < 300) begin @(posedge clk); #1; lat++; end
        if (!c_ready) chk("both_rd_timeout", DW'(0), DW'(1));
        d = c_rdata;
        c_read = 1'b0;
        $display("both addr=%h data=%h", a, d);
        @(posedge clk); #1;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!wb_empty && n < 1000) begin @(posedge clk); #1; n++; end
        if (!wb_empty) chk("drain_timeout", DW'(0), DW'(1));
    endtask

    initial begin
        logic [DW-1:0] d, got, exp;
        logic [AW-1:0] a;
        int lat, rcyc, t0, op;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_c_ready",   DW'(c_ready), DW'(0));
        chk("rst_mem_read",  DW'(mem_read), DW'(0));
        chk("rst_mem_write", DW'(mem_write), DW'(0));
        chk("rst_c_rdata",   c_rdata, '0);
        chk("rst_mem_addr",  DW'(mem_addr), DW'(0));
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_wb_empty",  DW'(wb_empty), DW'(1));
        chk("rst_wb_count",  DW'(wb_count), DW'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single write and drain
        lat_min = 4; lat_max = 4;
        cache_write(28'h0000010, {16{8'hA5}}, lat, rcyc);
        chk("t1_lat", DW'(lat), DW'(1));
        chk("t1_count", DW'(wb_count), DW'(1));
        t0 = 0;
        while (!mem_write && t0 < 20) begin @(posedge clk); #1; t0++; end
        chk("t1_mem_write", DW'(mem_write), DW'(1));
        chk("t1_mem_addr", DW'(mem_addr), DW'(28'h0000010));
        wait_empty();
        chk("t1_count_end", DW'(wb_count), DW'(0));
        chk("t1_phys", phys_rd(28'h0000010), {16{8'hA5}});

        // 2: overfill with slow memory
        lat_min = 8; lat_max = 8;
        tx_log.delete();
        for (int i = 0; i < 5; i++) begin
            cache_write(28'h10 + AW'(i), {4{32'h2000_0000 + 32'(i)}}, lat, rcyc);
            if (i < 4) chk("t2_lat", DW'(lat), DW'(1));
            else       chk("t2_fifth_ready_cyc", DW'(rcyc), DW'(wr_ready_edge + 1));
        end
        wait_empty();
        chk("t2_drains", DW'(tx_log.size()), DW'(5));
        for (int i = 0; i < 5 && i < tx_log.size(); i++)
            chk("t2_order", DW'(tx_log[i]), DW'({1'b0, 28'h10 + AW'(i)}));

        // 3: read hit on a buffered line
        lat_min = 4; lat_max = 4;
        t0 = tx_starts;
        cache_write(28'h20, {4{32'hD1D1_D1D1}}, lat, rcyc);
        cache_read(28'h20, got, lat);
        chk("t3_lat", DW'(lat), DW'(1));
        chk("t3_data", got, {4{32'hD1D1_D1D1}});
        wait_empty();
        chk("t3_no_mem_read", DW'(tx_starts - t0), DW'(1));

        // 4: coalescing behind a draining head
        lat_min = 10; lat_max = 10;
        cache_write(28'h31, {4{32'h3131_3131}}, lat, rcyc);
        chk("t4_head_drain", DW'({mem_write, mem_addr}), DW'({1'b1, 28'h31}));
        cache_write(28'h30, {4{32'hE1E1_E1E1}}, lat, rcyc);
        cache_write(28'h30, {4{32'hE2E2_E2E2}}, lat, rcyc);
        chk("t4_count", DW'(wb_count), DW'(2));
        wait_empty();
        chk("t4_phys30", phys_rd(28'h30), {4{32'hE2E2_E2E2}});
        chk("t4_phys31", phys_rd(28'h31), {4{32'h3131_3131}});

        // 5: read miss behind an in-flight drain
        lat_min = 6; lat_max = 6;
        tx_log.delete();
        cache_write(28'h50, {4{32'h5050_5050}}, lat, rcyc);
        cache_write(28'h51, {4{32'h5151_5151}}, lat, rcyc);
        cache_read(28'h40, got, lat);
        chk("t5_data", got, init_line(28'h40));
        chk("t5_rd_issue_cyc", DW'(rd_start_cyc), DW'(wr_ready_edge + 1));
        wait_empty();
        chk("t5_n_tx", DW'(tx_log.size()), DW'(3));
        if (tx_log.size() == 3) begin
            chk("t5_tx0", DW'(tx_log[0]), DW'({1'b0, 28'h50}));
            chk("t5_tx1", DW'(tx_log[1]), DW'({1'b1, 28'h40}));
            chk("t5_tx2", DW'(tx_log[2]), DW'({1'b0, 28'h51}));
        end

        // 6: reset mid-drain discards everything
        lat_min = 20; lat_max = 20;
        for (int i = 0; i < 3; i++)
            cache_write(28'h60 + AW'(i), {4{32'h6000_0000 + 32'(i)}}, lat, rcyc);
        chk("t6_draining", DW'(mem_write), DW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_mem_write", DW'(mem_write), DW'(0));
        chk("t6_count", DW'(wb_count), DW'(0));
        chk("t6_empty", DW'(wb_empty), DW'(1));
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        ref_mem = phys;
        t0 = tx_starts;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_no_traffic", DW'(tx_starts - t0), DW'(0));
        chk("t6_phys60", phys_rd(28'h60), init_line(28'h60));

        // Random traffic over a small address pool to exercise hits, coalescing and full stalls
        lat_min = 1; lat_max = 6;
        spurious_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = 28'h100 + AW'($urandom_range(7, 0));
            d = {$urandom, $urandom, $urandom, $urandom};
            op = int'($urandom_range(9, 0));
            if (op < 5) begin
                cache_write(a, d, lat, rcyc);
            end else if (op < 9) begin
                exp = ref_rd(a);
                cache_read(a, got, lat);
                chk("rand_read", got, exp);
            end else begin
                cache_both(a, d, got);
                chk("both_read", got, d);
            end
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        end
        wait_empty();
        spurious_en = 1'b0;
        foreach (ref_mem[k]) chk("final_mem", phys_rd(k), ref_mem[k]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
